// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single shared memory port with wait timeout.
// Optional macro MEM_ARB_RR_EN: alternate grants on simultaneous requests instead of data-first.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [9:0] LP_CNT_LAST = 10'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_if_valid;
    logic        r_d_valid;
    logic        r_err;

    logic        w_if_pend;
    logic        w_d_pend;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_busy;
    logic        w_done;
    logic        w_tmo;

    // A requester whose valid is pulsing this cycle is finishing, not asking again.
    assign w_if_pend = if_req & ~r_if_valid;
    assign w_d_pend  = d_req & ~r_d_valid;

`ifdef MEM_ARB_RR_EN
    logic r_last_d;

    assign w_grant_d = w_d_pend & (~w_if_pend | ~r_last_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && (w_grant_d || w_grant_i)) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_pend;
`endif

    assign w_grant_i = w_if_pend & ~w_grant_d;
    assign w_busy    = (r_state != IDLE);
    assign w_done    = w_busy & mem_ready;
    assign w_tmo     = w_busy & ~mem_ready & (r_cnt == LP_CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done || w_tmo) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_grant_d) begin
                    r_addr   <= d_addr;
                    r_wdata  <= d_wdata;
                    r_funct3 <= d_funct3;
                    r_we     <= d_we;
                end else if (w_grant_i) begin
                    r_addr   <= if_addr;
                    r_wdata  <= '0;
                    r_funct3 <= 3'b010;
                    r_we     <= 1'b0;
                end
            end else if (w_done) begin
                if (r_state == BUSY_I) begin
                    r_if_rdata <= mem_rdata;
                    r_if_valid <= 1'b1;
                end else begin
                    if (!r_we) begin
                        r_d_rdata <= mem_rdata;
                    end
                    r_d_valid <= 1'b1;
                end
            end else if (w_tmo) begin
                r_err <= 1'b1;
                if (r_state == BUSY_I) begin
                    r_if_rdata <= '0;
                    r_if_valid <= 1'b1;
                end else begin
                    r_d_rdata <= '0;
                    r_d_valid <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 10'd1;
            end
        end
    end

    assign mem_en     = w_busy;
    assign mem_we     = w_busy & r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_funct3 = r_funct3;

    assign if_rdata = r_if_rdata;
    assign if_valid = r_if_valid;
    assign d_rdata  = r_d_rdata;
    assign d_valid  = r_d_valid;
    assign err      = r_err;

    assign stall_f = if_req & ~r_if_valid;
    assign stall_m = d_req & ~r_d_valid;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles an access waits for mem_ready before it is aborted (range 1..1023).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports if_req (in, 1), if_addr (in, 32), if_rdata (out, 32) and if_valid (out, 1): the instruction-fetch requester.
REQ-005 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_funct3 (in, 3), d_rdata (out, 32) and d_valid (out, 1): the data (MEM-stage) requester.
REQ-006 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_funct3 (out, 3), mem_rdata (in, 32) and mem_ready (in, 1): the single shared memory port.
REQ-007 SHALL have ports stall_f (out, 1), stall_m (out, 1) and err (out, 1): pipeline stall controls and the timeout flag.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_I and BUSY_D.
REQ-009 In IDLE, a request SHALL be latched (addr, we, wdata, funct3) and the FSM SHALL move to BUSY_D (data) or BUSY_I (fetch) on the next edge.
REQ-010 Priority when both requesters are active in IDLE: data wins, unless changed by the Configuration section.
REQ-011 In BUSY_x, mem_en SHALL be 1 and mem_* SHALL drive the latched values, held stable until completion; mem_we SHALL be 0 in BUSY_I.
REQ-012 In IDLE, mem_en and mem_we SHALL be 0.
REQ-013 Completion is the cycle mem_ready=1 while BUSY_x: the arbiter SHALL register mem_rdata into x_rdata, pulse x_valid for exactly 1 cycle on the next cycle, and return to IDLE.
REQ-014 Read latency: request in IDLE at cycle N with mem_ready already 1 SHALL give x_valid at cycle N+2; each extra wait cycle adds 1.
REQ-015 x_rdata SHALL hold its last value until the next completion for that requester.
REQ-016 For a data write (d_we=1), d_valid SHALL still pulse and d_rdata SHALL be left unchanged.
REQ-017 stall_f SHALL equal if_req AND NOT if_valid, combinationally.
REQ-018 stall_m SHALL equal d_req AND NOT d_valid, combinationally.
REQ-019 A requester SHALL hold its req and operands until its valid pulse; deassertion before that is ignored and the latched access completes.
REQ-020 A wait counter SHALL clear on entry to BUSY_x and increment each cycle without mem_ready.
REQ-021 Timeout: when the counter reaches TIMEOUT, the FSM SHALL return to IDLE, pulse x_valid with x_rdata=0, and set err.
REQ-022 err SHALL be sticky and clear only on reset.
REQ-023 mem_ready while IDLE SHALL be ignored.
REQ-024 At least one IDLE cycle SHALL separate consecutive accesses.
REQ-025 A request arriving while BUSY SHALL wait, and SHALL be granted in the IDLE cycle following completion.

Reset
REQ-026 While reset=0, the FSM SHALL be IDLE, the counter 0, if_rdata/d_rdata 0, if_valid/d_valid 0, err 0, mem_en/mem_we 0 and mem_addr/mem_wdata/mem_funct3 0.
REQ-027 Reset mid-access SHALL abort the access with no valid pulse.
REQ-028 The first grant SHALL be possible in the first cycle after reset rises.

Configuration
REQ-029 Macro MEM_ARB_RR_EN: when defined, a 1-bit last-served flag (reset value: fetch) SHALL make simultaneous requests in IDLE go to the requester not served last.
REQ-030 When MEM_ARB_RR_EN is not defined, data SHALL always win (REQ-010) and the flag SHALL not exist.

Verification
REQ-031 if_req=1, if_addr=0x00000010, mem_ready=1, mem_rdata=0x00500093 -> mem_en in cycle 1, if_valid=1 with if_rdata=0x00500093 in cycle 2, stall_f=0 in cycle 2.
REQ-032 if_req and d_req both raised at once, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> data served first (mem_we=1, mem_addr=0x100), fetch granted after the idle cycle; with MEM_ARB_RR_EN and last-served=data, fetch is served first instead.
REQ-033 mem_ready held 0 for 3 cycles during a data read of 0x1234 -> d_valid exactly 3 cycles later than the zero-wait case, stall_m=1 throughout.
REQ-034 TIMEOUT=4, mem_ready never asserted -> after 4 wait cycles, return to IDLE, d_valid=1 with d_rdata=0, err=1 and staying 1.
REQ-035 reset driven low during BUSY_I -> mem_en=0 immediately, no if_valid pulse, all outputs at reset values; a new fetch after release completes normally.
